// File: rtl/counter_0_to_9675.sv
// Four-digit BCD up/down counter (0..MAX_COUNT, wrapping) with active-low seven-segment outputs.
// Define COUNTER_PRESCALER_EN to slow counting to one step per PRESCALE enabled clock cycles.
module counter_0_to_9675 #(
    parameter int MAX_COUNT = 9675,
    parameter int PRESCALE  = 50000000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [3:0] LEDR
);

    localparam logic [3:0][3:0] MAX_BCD = {
        4'((MAX_COUNT / 1000) % 10),
        4'((MAX_COUNT / 100) % 10),
        4'((MAX_COUNT / 10) % 10),
        4'(MAX_COUNT % 10)
    };

    logic            rst;
    logic            clear_s;
    logic            down_s;
    logic            enable_s;
    logic            tick_s;
    logic            at_max_s;
    logic            at_zero_s;
    logic [3:0][3:0] digit_r;
    logic [3:0][3:0] inc_s;
    logic [3:0][3:0] dec_s;
    logic [3:0][3:0] next_s;

    assign rst      = SW[3];
    assign clear_s  = SW[2];
    assign down_s   = SW[1];
    assign enable_s = SW[0];

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

`ifdef COUNTER_PRESCALER_EN
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pre_r;

    assign tick_s = (pre_r == PW'(PRESCALE - 1));

    // Prescaler: runs only while enabled, restarts on clear and after each tick.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
        end else if (clear_s) begin
            pre_r <= '0;
        end else if (enable_s) begin
            pre_r <= tick_s ? '0 : pre_r + PW'(1);
        end else begin
            pre_r <= pre_r;
        end
    end
`else
    // Legal PRESCALE is at least 2, so this is a constant high tick.
    assign tick_s = (PRESCALE > 0);
`endif

    assign at_max_s  = (digit_r == MAX_BCD);
    assign at_zero_s = (digit_r == '0);

    // Decimal increment/decrement with ripple carry/borrow and wrap at the limits.
    always_comb begin
        logic carry;
        logic borrow;
        inc_s  = digit_r;
        dec_s  = digit_r;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (digit_r[i] >= 4'd9) begin
                    inc_s[i] = 4'd0;
                    carry    = 1'b1;
                end else begin
                    inc_s[i] = digit_r[i] + 4'd1;
                    carry    = 1'b0;
                end
            end else begin
                inc_s[i] = digit_r[i];
            end
            if (borrow) begin
                if (digit_r[i] == 4'd0) begin
                    dec_s[i] = 4'd9;
                    borrow   = 1'b1;
                end else begin
                    dec_s[i] = digit_r[i] - 4'd1;
                    borrow   = 1'b0;
                end
            end else begin
                dec_s[i] = digit_r[i];
            end
        end
        if (at_max_s) begin
            inc_s = '0;
        end else begin
            inc_s = inc_s;
        end
        if (at_zero_s) begin
            dec_s = MAX_BCD;
        end else begin
            dec_s = dec_s;
        end
    end

    // Next count: clear beats step beats hold.
    always_comb begin
        next_s = digit_r;
        if (clear_s) begin
            next_s = '0;
        end else if (enable_s && tick_s) begin
            next_s = down_s ? dec_s : inc_s;
        end else begin
            next_s = digit_r;
        end
    end

    // Digit registers.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            digit_r <= '0;
        end else begin
            digit_r <= next_s;
        end
    end

    assign HEX0 = seg_decode(digit_r[0]);
    assign HEX1 = seg_decode(digit_r[1]);
    assign HEX2 = seg_decode(digit_r[2]);
    assign HEX3 = seg_decode(digit_r[3]);
    assign LEDR = {at_zero_s, at_max_s, down_s, enable_s};

endmodule

// File: tb/tb_counter_0_to_9675.sv
// Directed bench for counter_0_to_9675 in the default (no prescaler) build.
module tb_counter_0_to_9675;

    logic       clk;
    logic [3:0] sw;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic [3:0] ledr;
    int         n_vec;
    int         n_miss;
    logic [6:0] seg_tab [10];

    counter_0_to_9675 dut (
        .CLOCK_50 (clk),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .LEDR     (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_disp(input string tag, input int value, input logic [3:0] led);
        logic [27:0] exp_hex;
        exp_hex = {seg_tab[(value / 1000) % 10], seg_tab[(value / 100) % 10],
                   seg_tab[(value / 10) % 10], seg_tab[value % 10]};
        check({tag, "_hex"}, {4'd0, hex3, hex2, hex1, hex0}, {4'd0, exp_hex});
        check({tag, "_led"}, {28'd0, ledr}, {28'd0, led});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

        sw = 4'b1000;
        cycles(2);
        check_disp("reset", 0, 4'b1000);
        check("reset_hex0", {25'd0, hex0}, {25'd0, 7'b1000000});

        sw = 4'b0000;
        cycles(25);
        check_disp("idle", 0, 4'b1000);

        sw = 4'b0001;
        cycles(25);
        check_disp("up25", 25, 4'b0001);
        check("up25_hex0", {25'd0, hex0}, {25'd0, 7'b0010010});
        check("up25_hex1", {25'd0, hex1}, {25'd0, 7'b0100100});

        sw = 4'b0000;
        cycles(3);
        check_disp("hold", 25, 4'b0000);

        // Direction change: up to 30, then down three steps.
        sw = 4'b0001;
        cycles(5);
        sw = 4'b0011;
        cycles(3);
        check_disp("dirchg", 27, 4'b0011);

        sw = 4'b0100;
        cycles(1);
        check_disp("clear", 0, 4'b1000);

        sw = 4'b0011;
        cycles(1);
        check_disp("dnwrap", 9675, 4'b0111);
        cycles(10);
        check_disp("dn9665", 9665, 4'b0011);

        sw = 4'b0100;
        cycles(1);
        sw = 4'b0001;
        cycles(999);
        check_disp("c0999", 999, 4'b0001);
        cycles(1);
        check_disp("c1000", 1000, 4'b0001);
        cycles(8674);
        check_disp("c9674", 9674, 4'b0001);
        cycles(1);
        check_disp("c9675", 9675, 4'b0101);
        cycles(1);
        check_disp("upwrap", 0, 4'b1001);

        cycles(42);
        check_disp("c0042", 42, 4'b0001);
        sw = 4'b0101;
        cycles(1);
        check_disp("clr_en", 0, 4'b1001);
        sw = 4'b0110;
        cycles(1);
        check_disp("clr_dn", 0, 4'b1010);

        sw = 4'b0001;
        cycles(137);
        check_disp("c0137", 137, 4'b0001);
        #2;
        sw = 4'b1001;
        #1;
        check_disp("async", 0, 4'b1001);
        @(negedge clk);
        sw = 4'b0001;
        cycles(1);
        check_disp("resume", 1, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
